// File: rtl/data_io_buf.sv
// SPI file-download buffer: decodes IO-controller commands, writes payload bytes to RAM through a write FIFO,
// and zero-fills a scratch region on request. Optional per-download checksum under `DATA_IO_CHECKSUM_EN.
module data_io_buf #(
  parameter int unsigned     AW              = 25,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter logic [AW-1:0]   BASE_DEFAULT    = AW'('h200000),
  parameter logic [AW-1:0]   BASE_IDX0       = AW'('h180000),
  parameter logic [AW-1:0]   ERASE_START     = AW'('h1A0000),
  parameter logic [AW-1:0]   ERASE_END       = AW'('h1BFFFF),
  parameter logic [AW-1:0]   ERASE_TRIG_SIZE = AW'('h002000),
  parameter int unsigned     ERASE_DIV       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sck,
  input  logic          ss,
  input  logic          sdi,
  input  logic          force_erase,
  input  logic          ram_rdy,
  output logic          downloading,
  output logic [AW-1:0] size,
  output logic [4:0]    index,
  output logic          overflow,
  output logic          wr,
  output logic [AW-1:0] a,
  output logic [7:0]    d,
  output logic [7:0]    checksum
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = (ERASE_DIV > 1) ? $clog2(ERASE_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DL, S_DRAIN, S_ERASE} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } entry_t;

  logic [1:0]    sck_s_q, ss_s_q, sdi_s_q, fe_s_q;
  logic          sck_prev_q, fe_prev_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    sr_q, sr_d;
  logic [7:0]    cmd_q, cmd_d;
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] size_q, size_d;
  logic [4:0]    index_q, index_d;
  logic          ovf_q, ovf_d;
  logic          erase_req_q, erase_req_d;
  logic [AW-1:0] ea_q, ea_d;
  logic [DW-1:0] div_q, div_d;
  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef DATA_IO_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic       sck_rise, fe_rise, byte_done;
  logic [7:0] byte_c;
  logic       is_start, is_end, is_dat, is_idx;
  logic       fifo_full, fifo_empty, push, pop, erase_wr, accept;

  assign sck_rise   = sck_s_q[1] & ~sck_prev_q;
  assign fe_rise    = fe_s_q[1] & ~fe_prev_q;
  assign byte_c     = {sr_q, sdi_s_q[1]};
  assign byte_done  = sck_rise & ~ss_s_q[1] & (bit_cnt_q == 4'd15);
  assign is_start   = byte_done & (cmd_q == 8'h53) & byte_c[0];
  assign is_end     = byte_done & (cmd_q == 8'h53) & ~byte_c[0];
  assign is_dat     = byte_done & (cmd_q == 8'h54) & (state_q == S_DL);
  assign is_idx     = byte_done & (cmd_q == 8'h55);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = is_dat & ~fifo_full;
  assign erase_wr   = (state_q == S_ERASE) & (div_q == '0);
  assign accept     = wr & ram_rdy;
  assign pop        = accept & (state_q != S_ERASE);

  // The FIFO is always empty while erasing, so the write port simply muxes between the two sources.
  assign wr          = erase_wr | ~fifo_empty;
  assign a           = (state_q == S_ERASE) ? ea_q : mem_q[rd_ptr_q].addr;
  assign d           = (state_q == S_ERASE) ? 8'h00 : mem_q[rd_ptr_q].data;
  assign downloading = (state_q != S_IDLE) | ~fifo_empty;
  assign size        = size_q;
  assign index       = index_q;
  assign overflow    = ovf_q;
`ifdef DATA_IO_CHECKSUM_EN
  assign checksum    = csum_q;
`else
  assign checksum    = 8'h00;
`endif

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    cmd_d       = cmd_q;
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    index_d     = index_q;
    ovf_d       = ovf_q;
    erase_req_d = erase_req_q;
    ea_d        = ea_q;
    div_d       = div_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
`ifdef DATA_IO_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    // Bit counter: 0..7 command byte, then 8..15 per data byte.
    if (ss_s_q[1]) begin
      bit_cnt_d = 4'd0;
    end else if (sck_rise) begin
      sr_d = byte_c[6:0];
      if (bit_cnt_q == 4'd7) cmd_d = byte_c;
      bit_cnt_d = (bit_cnt_q == 4'd15) ? 4'd8 : bit_cnt_q + 4'd1;
    end

    if (is_idx) index_d = byte_c[4:0];

    // Dropped bytes still advance address and size so later bytes land where they belong.
    if (is_dat) begin
      addr_d = addr_q + AW'(1);
      size_d = size_q + AW'(1);
      if (fifo_full) ovf_d = 1'b1;
`ifdef DATA_IO_CHECKSUM_EN
      else csum_d = csum_q + byte_c;
`endif
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        if (fe_rise) begin
          state_d = S_ERASE;
          ea_d    = ERASE_START;
          div_d   = '0;
        end
      end
      S_DL: begin
        if (fe_rise) erase_req_d = 1'b1;
        if (is_end) begin
          state_d = S_DRAIN;
          if ((index_q == 5'd0) && (size_q == ERASE_TRIG_SIZE)) erase_req_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (fe_rise) erase_req_d = 1'b1;
        if (fifo_empty) begin
          if (erase_req_q | fe_rise) begin
            state_d     = S_ERASE;
            erase_req_d = 1'b0;
            ea_d        = ERASE_START;
            div_d       = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ERASE: begin
        if (div_q != '0) div_d = div_q - DW'(1);
        if (accept) begin
          if (ea_q == ERASE_END) begin
            state_d = S_IDLE;
          end else begin
            ea_d  = ea_q + AW'(1);
            div_d = DW'(ERASE_DIV - 1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A start wins over anything the current state was doing, including an erase in progress.
    if (is_start) begin
      state_d = S_DL;
      addr_d  = (index_q == 5'd0) ? BASE_IDX0 : BASE_DEFAULT;
      size_d  = '0;
      ovf_d   = 1'b0;
`ifdef DATA_IO_CHECKSUM_EN
      csum_d  = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s_q     <= '0;
      ss_s_q      <= '0;
      sdi_s_q     <= '0;
      fe_s_q      <= '0;
      sck_prev_q  <= 1'b0;
      fe_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      cmd_q       <= '0;
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      index_q     <= '0;
      ovf_q       <= 1'b0;
      erase_req_q <= 1'b0;
      ea_q        <= '0;
      div_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
`ifdef DATA_IO_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      sck_s_q     <= {sck_s_q[0], sck};
      ss_s_q      <= {ss_s_q[0], ss};
      sdi_s_q     <= {sdi_s_q[0], sdi};
      fe_s_q      <= {fe_s_q[0], force_erase};
      sck_prev_q  <= sck_s_q[1];
      fe_prev_q   <= fe_s_q[1];
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      cmd_q       <= cmd_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      index_q     <= index_d;
      ovf_q       <= ovf_d;
      erase_req_q <= erase_req_d;
      ea_q        <= ea_d;
      div_q       <= div_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= '{addr: addr_q, data: byte_c};
`ifdef DATA_IO_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_io_buf.sv
// Bench for data_io_buf: drives SPI command sequences and checks RAM writes, status outputs and the
// erase sweep against a transaction-level model (expected-write queue). Erase region is shrunk for run time.
module tb_data_io_buf;

  localparam int unsigned   AW        = 25;
  localparam int unsigned   DEPTH     = 4;
  localparam logic [AW-1:0] B_DEF     = 25'h200000;
  localparam logic [AW-1:0] B_IDX0    = 25'h180000;
  localparam logic [AW-1:0] E_START   = 25'h1A0000;
  localparam logic [AW-1:0] E_END     = 25'h1A001F;
  localparam logic [AW-1:0] E_TRIG    = 25'h000020;
  localparam int unsigned   E_DIV     = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0, reset = 1'b1;
  logic          sck = 1'b0, ss = 1'b1, sdi = 1'b0, force_erase = 1'b0, ram_rdy = 1'b1;
  logic          downloading, overflow, wr;
  logic [AW-1:0] size, a;
  logic [4:0]    index;
  logic [7:0]    d, checksum;

  data_io_buf #(
    .AW(AW), .FIFO_DEPTH(DEPTH), .BASE_DEFAULT(B_DEF), .BASE_IDX0(B_IDX0),
    .ERASE_START(E_START), .ERASE_END(E_END), .ERASE_TRIG_SIZE(E_TRIG), .ERASE_DIV(E_DIV)
  ) dut (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi), .force_erase(force_erase),
    .ram_rdy(ram_rdy), .downloading(downloading), .size(size), .index(index),
    .overflow(overflow), .wr(wr), .a(a), .d(d), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int ram_mode = 0;   // 0 ready, 1 stalled, 2 toggling, 3 random

  // Reference model state
  wr_t           exp_q[$];
  logic [AW-1:0] m_addr = '0, m_size = '0;
  logic [4:0]    m_index = '0;
  logic          m_ovf = 1'b0, m_stall = 1'b0;
  logic [7:0]    m_csum = 8'h00;
  int            m_buf = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge clk) begin
    #1;
    case (ram_mode)
      0:       ram_rdy = 1'b1;
      1:       ram_rdy = 1'b0;
      2:       ram_rdy = ~ram_rdy;
      default: ram_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Write monitor: every accepted write must be the next expected one; stalled writes must hold.
  int            cyc = 0, last_er = 0;
  logic          stall_prev = 1'b0;
  logic [AW-1:0] held_a;
  logic [7:0]    held_d;
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (stall_prev && wr === 1'b1) begin
      check("hold_a", a, held_a);
      check("hold_d", d, held_d);
    end
    stall_prev = (wr === 1'b1) && !ram_rdy;
    held_a = a;
    held_d = d;
    if (wr === 1'b1 && ram_rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr", wr, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", a, e.addr);
        check("wr_data", d, e.data);
        if (e.addr >= E_START && e.addr <= E_END && e.data == 8'h00) begin
          if (e.addr != E_START) check("erase_gap_ok", 1'((cyc - last_er) >= int'(E_DIV)), 1'b1);
          last_er = cyc;
        end
      end
    end
  end

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sdi = b[i];
      #30 sck = 1'b1;
      #30 sck = 1'b0;
    end
  endtask

  task automatic spi_cmd(input logic [7:0] c, input logic [7:0] v);
    ss = 1'b0;
    #20 spi_byte(c);
    spi_byte(v);
    #20 ss = 1'b1;
    #60;
  endtask

  task automatic set_index(input logic [4:0] i);
    m_index = i;
    spi_cmd(8'h55, {3'b000, i});
  endtask

  task automatic start_dl();
    m_addr = (m_index == 5'd0) ? B_IDX0 : B_DEF;
    m_size = '0;
    m_ovf  = 1'b0;
    m_csum = 8'h00;
    m_buf  = 0;
    spi_cmd(8'h53, 8'h01);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$]);
    ss = 1'b0;
    #20 spi_byte(8'h54);
    foreach (bytes[k]) begin
      if (!m_stall || m_buf < int'(DEPTH)) begin
        exp_q.push_back('{addr: m_addr, data: bytes[k]});
        m_csum += bytes[k];
        if (m_stall) m_buf++;
      end else begin
        m_ovf = 1'b1;
      end
      m_addr += AW'(1);
      m_size += AW'(1);
      spi_byte(bytes[k]);
    end
    #20 ss = 1'b1;
    #60;
  endtask

  task automatic end_dl();
    if (m_index == 5'd0 && m_size == E_TRIG)
      for (logic [AW-1:0] x = E_START; x <= E_END; x++) exp_q.push_back('{addr: x, data: 8'h00});
    spi_cmd(8'h53, 8'h00);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (downloading !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, downloading, 1'b0);
    check({tag, "_all_writes_seen"}, exp_q.size(), 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_size"}, size, m_size);
    check({tag, "_index"}, index, m_index);
    check({tag, "_overflow"}, overflow, m_ovf);
`ifdef DATA_IO_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, m_csum);
`else
    check({tag, "_checksum"}, checksum, 8'h00);
`endif
  endtask

  initial begin
    logic [7:0] q[$];
    int n;

    // Reset state
    #23;
    check("rst_wr", wr, 1'b0);
    check("rst_dl", downloading, 1'b0);
    check("rst_a", a, '0);
    check("rst_d", d, 8'h00);
    check("rst_size", size, '0);
    check("rst_index", index, 5'd0);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Index 0, trigger-size download followed by the erase sweep
    start_dl();
    q = {};
    for (int i = 0; i < int'(E_TRIG); i++) q.push_back(8'(i));
    send_bytes(q);
    end_dl();
    wait_idle("t1");
    check_status("t1");

    // Non-zero index, 5 random bytes, no erase
    set_index(5'($urandom_range(1, 31)));
    start_dl();
    q = {};
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    send_bytes(q);
    end_dl();
    wait_idle("t2");
    check_status("t2");

    // RAM stalled: FIFO fills, overflow sets, buffered bytes drain on release
    ram_mode = 1;
    m_stall  = 1'b1;
    start_dl();
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    send_bytes(q);
    end_dl();
    check("t3_wr_pending", wr, 1'b1);
    check_status("t3_stalled");
    ram_mode = 0;
    m_stall  = 1'b0;
    wait_idle("t3");
    check_status("t3");

    // Toggling ready: writes must hold while stalled and stay in order
    ram_mode = 2;
    start_dl();
    check("t4_ovf_cleared", overflow, 1'b0);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    send_bytes(q);
    end_dl();
    wait_idle("t4");
    check_status("t4");

    // Random ready with a fresh random index
    ram_mode = 3;
    set_index(5'($urandom_range(1, 31)));
    start_dl();
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    send_bytes(q);
    end_dl();
    wait_idle("t5");
    check_status("t5");
    ram_mode = 0;

    // Index 0 but size below trigger: no erase; checksum example
    set_index(5'd0);
    start_dl();
    q = {8'hFF, 8'h02, 8'h10};
    send_bytes(q);
    end_dl();
    wait_idle("t6");
    check_status("t6");
`ifdef DATA_IO_CHECKSUM_EN
    check("t6_csum_example", checksum, 8'h11);
`else
    check("t6_csum_tied", checksum, 8'h00);
`endif

    // force_erase in IDLE, then reset in the middle of the sweep
    set_index(5'd9);
    for (logic [AW-1:0] x = E_START; x <= E_END; x++) exp_q.push_back('{addr: x, data: 8'h00});
    force_erase = 1'b1;
    repeat (4) @(posedge clk);
    force_erase = 1'b0;
    n = 0;
    while (exp_q.size() > 27 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t7_erase_progress", 1'(exp_q.size() <= 27), 1'b1);
    #2;
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("t7_rst_wr", wr, 1'b0);
    check("t7_rst_a", a, '0);
    check("t7_rst_d", d, 8'h00);
    check("t7_rst_dl", downloading, 1'b0);
    check("t7_rst_size", size, '0);
    check("t7_rst_index", index, 5'd0);
    check("t7_rst_ovf", overflow, 1'b0);
    check("t7_rst_csum", checksum, 8'h00);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("t7_no_wr_after", wr, 1'b0);
    check("t7_idle_after", downloading, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
